// File: rtl/spw_rx_ds_decoder.sv
// spw_rx_ds_decoder
//   Receive-side SpaceWire character decoder. Oversamples the asynchronous
//   Data/Strobe pair on the system clock, recovers one bit per D/S change and
//   decodes NULL, FCT, EOP, EEP, data and time-code characters with parity,
//   escape-sequence and disconnect checking.
// Ports
//   ppll_100_MHZ, reset_spw_n_b : clock, async active-low reset
//   rx_enable                   : low forces HUNT and silences every output
//   din, sin                    : raw Data / Strobe line inputs
//   rx_activity                 : pulse per recovered bit
//   got_null/got_fct            : link-FSM character pulses
//   got_data, rx_data[8:0]      : FIFO word (bit 8 set = EOP 0x00 / EEP 0x01)
//   got_time, rx_time[7:0]      : time-code pulse and byte
//   parity_error/esc_error/disconnect_error : error pulses
module spw_rx_ds_decoder #(
  parameter int DISC_CYCLES = 85
) (
  input  logic       ppll_100_MHZ,
  input  logic       reset_spw_n_b,
  input  logic       rx_enable,
  input  logic       din,
  input  logic       sin,
  output logic       rx_activity,
  output logic       got_null,
  output logic       got_fct,
  output logic       got_data,
  output logic [8:0] rx_data,
  output logic       got_time,
  output logic [7:0] rx_time,
  output logic       parity_error,
  output logic       esc_error,
  output logic       disconnect_error
);
  localparam int CW = $clog2(DISC_CYCLES + 1);
  typedef enum logic {HUNT, RUN} state_t;

  logic din_m_q, sin_m_q, din_s_q, sin_s_q, din_p_q, sin_p_q;
  logic din_m_d, sin_m_d, din_s_d, sin_s_d, din_p_d, sin_p_d;
  logic rx_activity_q, rx_activity_d, bit_val_q, bit_val_d;
  state_t state_q, state_d;
  logic [5:0] sh_q, sh_d;
  logic [3:0] cnt_q, cnt_d;
  logic p_q, p_d, c_q, c_d, ctl_q, ctl_d;
  logic [6:0] data_q, data_d;
  logic cur_par_q, cur_par_d, acc_q, acc_d, esc_q, esc_d;
  logic [CW-1:0] disc_cnt_q, disc_cnt_d;
  logic armed_q, armed_d;
  logic got_null_q, got_null_d, got_fct_q, got_fct_d, got_data_q, got_data_d;
  logic got_time_q, got_time_d, parity_error_q, parity_error_d;
  logic esc_error_q, esc_error_d, disconnect_error_q, disconnect_error_d;
  logic [8:0] rx_data_q, rx_data_d;
  logic [7:0] rx_time_q, rx_time_d;
  logic bit_now, go_hunt;
  logic [7:0] byte_w;
  logic [1:0] code_w;

  // One bit per change of the synchronized D/S pair against the prior sample.
  assign bit_now = ({din_s_q, sin_s_q} != {din_p_q, sin_p_q});
  assign byte_w  = {bit_val_q, data_q};
  assign code_w  = {ctl_q, bit_val_q};   // {first, second} payload bit

  always_comb begin
    din_m_d = din;      sin_m_d = sin;
    din_s_d = din_m_q;  sin_s_d = sin_m_q;
    din_p_d = din_s_q;  sin_p_d = sin_s_q;
    rx_activity_d = bit_now & rx_enable;
    bit_val_d = din_s_q;
    state_d = state_q;  sh_d = sh_q;   cnt_d = cnt_q;
    p_d = p_q;  c_d = c_q;  ctl_d = ctl_q;  data_d = data_q;
    cur_par_d = cur_par_q;  acc_d = acc_q;  esc_d = esc_q;
    disc_cnt_d = disc_cnt_q;  armed_d = armed_q;
    got_null_d = 1'b0;  got_fct_d = 1'b0;  got_data_d = 1'b0;  got_time_d = 1'b0;
    parity_error_d = 1'b0;  esc_error_d = 1'b0;  disconnect_error_d = 1'b0;
    rx_data_d = rx_data_q;  rx_time_d = rx_time_q;
    go_hunt = 1'b0;

    if (!rx_enable) begin
      armed_d = 1'b0;
      disc_cnt_d = '0;
      go_hunt = 1'b0;
      state_d = HUNT;  sh_d = '0;  cnt_d = '0;  acc_d = 1'b0;  esc_d = 1'b0;
    end else begin
      // Count starts at 1 on the cycle after a bit so the error lands
      // exactly DISC_CYCLES cycles after rx_activity.
      if (rx_activity_q) begin
        armed_d = 1'b1;
        disc_cnt_d = CW'(1);
      end else if (armed_q) begin
        if (disc_cnt_q == CW'(DISC_CYCLES - 1)) begin
          disconnect_error_d = 1'b1;
          armed_d = 1'b0;
          disc_cnt_d = '0;
          go_hunt = 1'b1;
        end else begin
          disc_cnt_d = disc_cnt_q + CW'(1);
        end
      end

      if (rx_activity_q) begin
        if (state_q == HUNT) begin
          sh_d = {sh_q[4:0], bit_val_q};
          // ESC tail (1,1,1) followed by FCT with P=0 (0,1,0,0)
          if ({sh_q, bit_val_q} == 7'b1110100) begin
            got_null_d = 1'b1;
            state_d = RUN;
            sh_d = '0;  cnt_d = '0;  acc_d = 1'b0;  esc_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd0) begin
            p_d = bit_val_q;
          end else if (cnt_q == 4'd1) begin
            c_d = bit_val_q;
            cur_par_d = 1'b0;
            // P covers the previous payload plus this C: odd parity
            if (!(acc_q ^ p_q ^ bit_val_q)) begin
              parity_error_d = 1'b1;
              go_hunt = 1'b1;
            end
          end else begin
            cur_par_d = cur_par_q ^ bit_val_q;
            ctl_d = bit_val_q;
            data_d = {bit_val_q, data_q[6:1]};
            if (c_q ? (cnt_q == 4'd3) : (cnt_q == 4'd9)) begin
              cnt_d = '0;
              acc_d = cur_par_q ^ bit_val_q;
              if (c_q) begin
                case (code_w)
                  2'b00: begin
                    if (esc_q) got_null_d = 1'b1;
                    else       got_fct_d  = 1'b1;
                    esc_d = 1'b0;
                  end
                  2'b01, 2'b10: begin
                    if (esc_q) begin
                      esc_error_d = 1'b1;
                      go_hunt = 1'b1;
                    end else begin
                      got_data_d = 1'b1;
                      rx_data_d = {1'b1, 7'd0, code_w[1]};
                    end
                    esc_d = 1'b0;
                  end
                  default: begin
                    if (esc_q) begin
                      esc_error_d = 1'b1;
                      go_hunt = 1'b1;
                    end else begin
                      esc_d = 1'b1;
                    end
                  end
                endcase
              end else begin
                if (esc_q) begin
                  got_time_d = 1'b1;
                  rx_time_d = byte_w;
                end else begin
                  got_data_d = 1'b1;
                  rx_data_d = {1'b0, byte_w};
                end
                esc_d = 1'b0;
              end
            end
          end
        end
      end

      if (go_hunt) begin
        state_d = HUNT;  sh_d = '0;  cnt_d = '0;  acc_d = 1'b0;  esc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge ppll_100_MHZ or negedge reset_spw_n_b) begin
    if (!reset_spw_n_b) begin
      din_m_q <= 1'b0;  sin_m_q <= 1'b0;  din_s_q <= 1'b0;  sin_s_q <= 1'b0;
      din_p_q <= 1'b0;  sin_p_q <= 1'b0;
      rx_activity_q <= 1'b0;  bit_val_q <= 1'b0;
      state_q <= HUNT;  sh_q <= '0;  cnt_q <= '0;
      p_q <= 1'b0;  c_q <= 1'b0;  ctl_q <= 1'b0;  data_q <= '0;
      cur_par_q <= 1'b0;  acc_q <= 1'b0;  esc_q <= 1'b0;
      disc_cnt_q <= '0;  armed_q <= 1'b0;
      got_null_q <= 1'b0;  got_fct_q <= 1'b0;  got_data_q <= 1'b0;  got_time_q <= 1'b0;
      parity_error_q <= 1'b0;  esc_error_q <= 1'b0;  disconnect_error_q <= 1'b0;
      rx_data_q <= '0;  rx_time_q <= '0;
    end else begin
      din_m_q <= din_m_d;  sin_m_q <= sin_m_d;  din_s_q <= din_s_d;  sin_s_q <= sin_s_d;
      din_p_q <= din_p_d;  sin_p_q <= sin_p_d;
      rx_activity_q <= rx_activity_d;  bit_val_q <= bit_val_d;
      state_q <= state_d;  sh_q <= sh_d;  cnt_q <= cnt_d;
      p_q <= p_d;  c_q <= c_d;  ctl_q <= ctl_d;  data_q <= data_d;
      cur_par_q <= cur_par_d;  acc_q <= acc_d;  esc_q <= esc_d;
      disc_cnt_q <= disc_cnt_d;  armed_q <= armed_d;
      got_null_q <= got_null_d;  got_fct_q <= got_fct_d;  got_data_q <= got_data_d;
      got_time_q <= got_time_d;  parity_error_q <= parity_error_d;
      esc_error_q <= esc_error_d;  disconnect_error_q <= disconnect_error_d;
      rx_data_q <= rx_data_d;  rx_time_q <= rx_time_d;
    end
  end

  assign rx_activity      = rx_activity_q;
  assign got_null         = got_null_q;
  assign got_fct          = got_fct_q;
  assign got_data         = got_data_q;
  assign rx_data          = rx_data_q;
  assign got_time         = got_time_q;
  assign rx_time          = rx_time_q;
  assign parity_error     = parity_error_q;
  assign esc_error        = esc_error_q;
  assign disconnect_error = disconnect_error_q;
endmodule

// File: tb/tb_spw_rx_ds_decoder.sv
// Bench for spw_rx_ds_decoder: DS-encodes characters onto din/sin, pushes the
// expected decoder events to a scoreboard queue and checks them as they appear.
module tb_spw_rx_ds_decoder;
  localparam int BITP = 10;
  localparam int DISC = 85;
  localparam int EV_NULL = 0, EV_FCT = 1, EV_DATA = 2, EV_TIME = 3;
  localparam int EV_PAR = 4, EV_ESC = 5, EV_DISC = 6;

  typedef struct {
    int         kind;
    logic [8:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n, rx_enable, din, sin;
  logic       rx_activity, got_null, got_fct, got_data, got_time;
  logic       parity_error, esc_error, disconnect_error;
  logic [8:0] rx_data;
  logic [7:0] rx_time;

  ev_t  sbq[$];
  int   checks = 0, errors = 0, cyc = 0, act_cnt = 0, last_act = 0;
  logic prev_par = 1'b0;

  always #5 clk = ~clk;

  spw_rx_ds_decoder #(.DISC_CYCLES(DISC)) dut (
    .ppll_100_MHZ(clk), .reset_spw_n_b(rst_n), .rx_enable(rx_enable),
    .din(din), .sin(sin), .rx_activity(rx_activity),
    .got_null(got_null), .got_fct(got_fct), .got_data(got_data),
    .rx_data(rx_data), .got_time(got_time), .rx_time(rx_time),
    .parity_error(parity_error), .esc_error(esc_error),
    .disconnect_error(disconnect_error)
  );

  task automatic push(input int kind, input logic [8:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input int kind);
    ev_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got kind %0d want none (cycle %0d)", kind, cyc);
    end else begin
      e = sbq.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL event_kind got %0d want %0d (cycle %0d)", kind, e.kind, cyc);
      end else if (kind == EV_DATA && rx_data !== e.val) begin
        errors++;
        $display("FAIL rx_data got %h want %h", rx_data, e.val);
      end else if (kind == EV_TIME && rx_time !== e.val[7:0]) begin
        errors++;
        $display("FAIL rx_time got %h want %h", rx_time, e.val[7:0]);
      end else if (kind == EV_DISC && (cyc - last_act) != DISC) begin
        errors++;
        $display("FAIL disc_delay got %0d want %0d", cyc - last_act, DISC);
      end
    end
  endtask

  // Every wait goes through here so observed pulses are scoreboarded each cycle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rx_activity) begin
      act_cnt++;
      last_act = cyc;
    end
    if (got_null)         sb_pop(EV_NULL);
    if (got_fct)          sb_pop(EV_FCT);
    if (got_data)         sb_pop(EV_DATA);
    if (got_time)         sb_pop(EV_TIME);
    if (parity_error)     sb_pop(EV_PAR);
    if (esc_error)        sb_pop(EV_ESC);
    if (disconnect_error) sb_pop(EV_DISC);
  endtask

  // DS encoding: D carries the bit, S toggles when D does not change.
  task automatic send_bit(input logic b);
    if (b != din) din = b;
    else          sin = ~sin;
    repeat (BITP) tick();
  endtask

  // pl holds payload bits in wire order (pl[0] first).
  task automatic send_char(input logic c, input logic [7:0] pl, input int n,
                           input logic bad);
    logic par;
    send_bit(1'b1 ^ prev_par ^ c ^ bad);
    send_bit(c);
    par = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_bit(pl[i]);
      par ^= pl[i];
    end
    prev_par = par;
  endtask

  task automatic send_fct();            send_char(1'b1, 8'h00, 2, 1'b0); endtask
  task automatic send_eop();            send_char(1'b1, 8'h02, 2, 1'b0); endtask
  task automatic send_eep();            send_char(1'b1, 8'h01, 2, 1'b0); endtask
  task automatic send_esc();            send_char(1'b1, 8'h03, 2, 1'b0); endtask
  task automatic send_data(input logic [7:0] b); send_char(1'b0, b, 8, 1'b0); endtask
  task automatic send_null();           send_esc(); send_fct(); endtask

  task automatic drain();
    repeat (100) tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d want 0 (next kind %0d)", sbq.size(), sbq[0].kind);
    end
    sbq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_enable = 1'b0; din = 1'b0; sin = 1'b0;
    repeat (3) tick();
    checks++;
    if ({rx_activity, got_null, got_fct, got_data, got_time,
         parity_error, esc_error, disconnect_error} !== 8'h00) begin
      errors++;
      $display("FAIL reset_pulses got %b want 0", {rx_activity, got_null, got_fct,
               got_data, got_time, parity_error, esc_error, disconnect_error});
    end
    checks++;
    if (rx_data !== 9'h000 || rx_time !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h/%h want 000/00", rx_data, rx_time);
    end
    rst_n = 1'b1; rx_enable = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_null_sync();
    int a0;
    a0 = act_cnt;
    for (int i = 0; i < 4; i++) begin
      push(EV_NULL, 9'h0);
      send_null();
    end
    push(EV_DISC, 9'h0);
    drain();
    checks++;
    if (act_cnt - a0 != 32) begin
      errors++;
      $display("FAIL activity_count got %0d want 32", act_cnt - a0);
    end
  endtask

  task automatic test_data_eop();
    push(EV_NULL, 9'h0);   send_null();
    push(EV_DATA, 9'h0A5); send_data(8'hA5);
    push(EV_DATA, 9'h100); send_eop();
    push(EV_DISC, 9'h0);
    drain();
  endtask

  task automatic test_fct_eep();
    push(EV_NULL, 9'h0);   send_null();
    push(EV_FCT, 9'h0);    send_fct();
    push(EV_DATA, 9'h101); send_eep();
    push(EV_DATA, 9'h000); send_data(8'h00);
    push(EV_DATA, 9'h0FF); send_data(8'hFF);
    push(EV_DISC, 9'h0);
    drain();
  endtask

  task automatic test_time();
    push(EV_NULL, 9'h0);   send_null();
    send_esc();
    push(EV_TIME, 9'h03F); send_data(8'h3F);
    push(EV_DATA, 9'h012); send_data(8'h12);
    push(EV_DISC, 9'h0);
    drain();
  endtask

  task automatic test_parity();
    push(EV_NULL, 9'h0);   send_null();
    push(EV_PAR, 9'h0);    send_char(1'b1, 8'h00, 2, 1'b1);
    push(EV_NULL, 9'h0);   send_null();
    push(EV_DISC, 9'h0);
    drain();
  endtask

  task automatic test_esc_err();
    push(EV_NULL, 9'h0);   send_null();
    send_esc();
    push(EV_ESC, 9'h0);    send_eop();
    push(EV_NULL, 9'h0);   send_null();
    send_esc();
    push(EV_ESC, 9'h0);    send_esc();
    push(EV_DISC, 9'h0);
    drain();
  endtask

  task automatic test_disable();
    int a0;
    rx_enable = 1'b0;
    a0 = act_cnt;
    send_null();
    drain();
    checks++;
    if (act_cnt != a0) begin
      errors++;
      $display("FAIL disabled_activity got %0d want 0", act_cnt - a0);
    end
    rx_enable = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    push(EV_NULL, 9'h0);   send_null();
    push(EV_DATA, 9'h05A); send_data(8'h5A);
    send_bit(1'b1 ^ prev_par);   // P of a data char
    send_bit(1'b0);              // C
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_activity, got_null, got_fct, got_data, got_time,
         parity_error, esc_error, disconnect_error} !== 8'h00) begin
      errors++;
      $display("FAIL midreset_pulses got %b want 0", {rx_activity, got_null, got_fct,
               got_data, got_time, parity_error, esc_error, disconnect_error});
    end
    checks++;
    if (rx_data !== 9'h000 || rx_time !== 8'h00) begin
      errors++;
      $display("FAIL midreset_data got %h/%h want 000/00", rx_data, rx_time);
    end
    din = 1'b0; sin = 1'b0; prev_par = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    drain();
  endtask

  initial begin
    test_reset();
    test_null_sync();
    test_data_eop();
    test_fct_eep();
    test_time();
    test_parity();
    test_esc_err();
    test_disable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
